gpr_bank: RTL and testbench
===========================

GPR_BANK -- requirements
Module: gpr_bank

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL hardwire entry 0 to zero when 1; entry 0 is an ordinary register when 0.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 gpr_reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 a1, a2  input  ADDR_W  SHALL be the read addresses for ports 1 and 2.
REQ-007 rd1, rd2  output  DATA_W  SHALL be the combinational read data for ports 1 and 2.
REQ-008 we0, a3, wd0  input  1/ADDR_W/DATA_W  SHALL be write port 0: enable, address, data.
REQ-009 we1, a4, wd1  input  1/ADDR_W/DATA_W  SHALL be write port 1: enable, address, data.
REQ-010 clr_req  input  1  SHALL request a sequential clear of all entries.
REQ-011 busy  output  1  SHALL be high while a sequential clear is in progress.
REQ-012 clr_done  output  1  SHALL pulse high for one cycle when a sequential clear completes.

Function
REQ-013 Writes SHALL commit on the rising clk edge when the enable is high and busy is low.
REQ-014 If we0 and we1 are both high with a3 == a4, wd1 SHALL be stored and wd0 discarded.
REQ-015 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including through forwarding.
REQ-016 The clear FSM SHALL have two states, IDLE and CLEAR, and SHALL reset to IDLE.
REQ-017 In IDLE, clr_req=1 SHALL move the FSM to CLEAR on the next edge with the clear counter at 0.
REQ-018 In CLEAR, each cycle SHALL zero the entry at the counter and increment the counter by 1.
REQ-019 In CLEAR with counter == DEPTH-1, the FSM SHALL zero that entry, return to IDLE, and assert clr_done for that following cycle; a full clear takes exactly DEPTH cycles.
REQ-020 busy SHALL equal (state == CLEAR).
REQ-021 clr_req in CLEAR SHALL be ignored; clr_req held high continuously SHALL start a new clear in the first IDLE cycle after clr_done.
REQ-022 Writes on either port while busy=1 SHALL be dropped without side effect.
REQ-023 Reads while busy=1 SHALL return current storage: 0 for already-cleared entries, old contents otherwise.
REQ-024 The counter SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 within one clear.

Reset
REQ-025 gpr_reset=1 at a rising edge SHALL zero all DEPTH entries in that cycle, set state=IDLE, counter=0, busy=0 and clr_done=0.
REQ-026 gpr_reset SHALL take priority over clr_req, writes and an in-progress clear (abort mid-clear, no clr_done pulse).
REQ-027 Storage SHALL be reset only through gpr_reset; level-sensitive or asynchronous clearing SHALL NOT be used.

Configuration
REQ-028 With macro GPR_BYPASS_EN defined, a read whose address matches an active write (enable high, busy low, not the hardwired zero entry) SHALL return that write's data in the same cycle, with port 1 taking priority over port 0.
REQ-029 Without GPR_BYPASS_EN, reads SHALL return stored contents only, so new data becomes visible the cycle after the write.

Verification
REQ-030 gpr_reset=1 for 1 cycle, then read a1=7, a2=31 -> rd1=0, rd2=0, busy=0, clr_done=0.
REQ-031 we0=1, a3=5, wd0=32'hDEAD_BEEF; a1=5 in the same cycle -> rd1=32'hDEAD_BEEF with GPR_BYPASS_EN, old value (0) without it; the next cycle rd1=32'hDEAD_BEEF in both builds.
REQ-032 we0=1, a3=9, wd0=32'h1111_1111 and we1=1, a4=9, wd1=32'h2222_2222 -> next cycle rd1 at a1=9 reads 32'h2222_2222.
REQ-033 With ZERO_REG=1: we1=1, a4=0, wd1=32'hFFFF_FFFF, a1=0 -> rd1=0 in the same cycle and on every later cycle.
REQ-034 Fill entries 1..31 with nonzero data, pulse clr_req -> busy=1 for exactly 32 cycles, clr_done high for 1 cycle, then all reads return 0; we0 at address 3 with wd0=32'h5 during busy is dropped.
REQ-035 Assert gpr_reset 10 cycles into a clear -> next cycle busy=0, clr_done stays 0, all entries read 0.

Source files
------------

// File: rtl/gpr_bank.sv
// Multi-port general-purpose register bank: two combinational read ports, two
// write ports (port 1 wins on collision) and a one-entry-per-cycle clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining GPR_BYPASS_EN.
module gpr_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              gpr_reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] a4,
  input  logic [DATA_W-1:0] wd1,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr0_ok, wr1_ok;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  // A write only lands when the sequencer is idle and it does not target the hardwired entry.
  assign wr0_ok = we0 && !busy && !is_zero_reg(a3);
  assign wr1_ok = we1 && !busy && !is_zero_reg(a4);

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    mem_d      = mem_q;

    case (state_q)
      IDLE: begin
        if (wr0_ok) mem_d[a3] = wd0;
        if (wr1_ok) mem_d[a4] = wd1;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LAST_IDX) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (gpr_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      // NOTE: the storage array is deliberately reset here; the bank must read
      // all-zero after reset, so this is not a flop-only reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef GPR_BYPASS_EN
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (wr1_ok && (a4 == addr)) return wd1;
    if (wr0_ok && (a3 == addr)) return wd0;
    return is_zero_reg(addr) ? '0 : mem_q[addr];
  endfunction
`else
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    return is_zero_reg(addr) ? '0 : mem_q[addr];
  endfunction
`endif

  always_comb begin
    rd1 = read_port(a1);
    rd2 = read_port(a2);
  end

endmodule

// File: tb/tb_gpr_bank.sv
// Self-checking bench for gpr_bank: directed scenarios with literal expectations,
// then random traffic compared every cycle against an array-based reference model.
module tb_gpr_bank;

  logic        clk = 1'b0;
  logic        gpr_reset;
  logic [4:0]  a1, a2, a3, a4;
  logic [31:0] rd1, rd2, wd0, wd1;
  logic        we0, we1, clr_req, busy, clr_done;

  int n_checks = 0;
  int n_fails  = 0;
  bit run_chk  = 1'b0;

  // Reference model: storage contents, remaining clear cycles and the done pulse.
  logic [31:0] model_mem [32];
  int          clr_left;
  bit          done_flag;

  gpr_bank dut (
    .clk(clk), .gpr_reset(gpr_reset),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .we0(we0), .a3(a3), .wd0(wd0),
    .we1(we1), .a4(a4), .wd1(wd1),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef GPR_BYPASS_EN
    if (clr_left == 0) begin
      if (we1 && a4 == addr) return wd1;
      if (we0 && a3 == addr) return wd0;
    end
`endif
    return model_mem[addr];
  endfunction

  function automatic void model_step();
    if (gpr_reset) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
      clr_left  = 0;
      done_flag = 1'b0;
    end else if (clr_left > 0) begin
      model_mem[32 - clr_left] = 32'h0;
      clr_left  = clr_left - 1;
      done_flag = (clr_left == 0);
    end else begin
      done_flag = 1'b0;
      if (we0 && a3 != 5'd0) model_mem[a3] = wd0;
      if (we1 && a4 != 5'd0) model_mem[a4] = wd1;
      if (clr_req) clr_left = 32;
    end
  endfunction

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (run_chk) begin
      check("rd1", rd1, model_read(a1));
      check("rd2", rd2, model_read(a2));
      check("busy", {31'b0, busy}, {31'b0, clr_left > 0});
      check("clr_done", {31'b0, clr_done}, {31'b0, done_flag});
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0; gpr_reset = 1'b0;
  endtask

  task automatic expect_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #0.1;
      check(name, rd1 | rd2, 32'h0);
    end
  endtask

  initial begin
    int n;
    quiet();
    gpr_reset = 1'b1;
    a1 = '0; a2 = '0; a3 = '0; a4 = '0; wd0 = '0; wd1 = '0;
    step();
    run_chk = 1'b1;

    // Reset state
    quiet();
    a1 = 5'd7; a2 = 5'd31;
    #2;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, clr_done}, 32'h0);

    // Single write and forwarding behaviour
    we0 = 1'b1; a3 = 5'd5; wd0 = 32'hDEAD_BEEF; a1 = 5'd5;
    #2;
`ifdef GPR_BYPASS_EN
    check("fwd_same_cycle", rd1, 32'hDEAD_BEEF);
`else
    check("no_fwd_same_cycle", rd1, 32'h0);
`endif
    step();
    quiet();
    #2;
    check("write_next_cycle", rd1, 32'hDEAD_BEEF);

    // Colliding writes: port 1 wins
    we0 = 1'b1; a3 = 5'd9; wd0 = 32'h1111_1111;
    we1 = 1'b1; a4 = 5'd9; wd1 = 32'h2222_2222;
    step();
    quiet();
    a1 = 5'd9;
    #2;
    check("collision_port1_wins", rd1, 32'h2222_2222);

    // Hardwired zero entry
    we1 = 1'b1; a4 = 5'd0; wd1 = 32'hFFFF_FFFF; a1 = 5'd0;
    #2;
    check("zero_reg_same_cycle", rd1, 32'h0);
    step();
    quiet();
    #2;
    check("zero_reg_later", rd1, 32'h0);

    // Fill, then a full sequential clear with a write attempted mid-clear
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; a3 = 5'(i); wd0 = 32'hA5A5_0000 + i;
      step();
    end
    quiet();
    a1 = 5'd3;
    #2;
    check("fill_readback", rd1, 32'hA5A5_0003);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    #2;
    while (busy === 1'b1 && n < 40) begin
      if (n == 2) begin
        we0 = 1'b1; a3 = 5'd3; wd0 = 32'h5;
      end else begin
        we0 = 1'b0;
      end
      step();
      n++;
      #2;
    end
    quiet();
    check("clear_busy_cycles", 32'(n), 32'd32);
    check("clear_done_pulse", {31'b0, clr_done}, 32'h1);
    step();
    #2;
    check("clear_done_one_cycle", {31'b0, clr_done}, 32'h0);
    expect_all_zero("after_clear_zero");

    // Reset aborting a clear
    for (int i = 1; i < 8; i++) begin
      we1 = 1'b1; a4 = 5'(i); wd1 = 32'h0BAD_0000 + i;
      step();
    end
    quiet();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    gpr_reset = 1'b1;
    step();
    gpr_reset = 1'b0;
    #2;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, clr_done}, 32'h0);
    expect_all_zero("abort_zero");
    step();
    #2;
    check("abort_no_late_done", {31'b0, clr_done}, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      a3  = 5'($urandom_range(0, 31));
      a4  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      wd0 = $urandom;
      wd1 = $urandom;
      a1  = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 2) == 0) ? a4 : 5'($urandom_range(0, 31));
      if (c >= 2000 && c < 2100) clr_req = 1'b1;
      else clr_req = ($urandom_range(0, 79) == 0);
      gpr_reset = ($urandom_range(0, 399) == 0);
      step();
    end
    quiet();
    step();
    run_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
